// File: rtl/output_buffer_drain_pkg.sv
// Shared definitions for the output-buffer drain block.
//   - Default sizing for the buffer (DATA_W / ADDR_W / DEPTH).
//   - Drain FSM state encoding.
//   - bfp32 zero word, used when an entry is scrubbed after being read.
package output_buffer_drain_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 4;
  localparam int DEPTH_DEF  = 16;

  localparam logic [31:0] BFP32_ZERO = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    FIN  = 2'd3
  } drain_state_e;

endpackage

// File: rtl/output_buffer_drain_if.sv
// Read-back stream from the output buffer to the host/DMA side.
//   rd_valid : beat valid (source)
//   rd_ready : consumer accepts beat (sink)
//   rd_data  : beat data (source)
//   rd_addr  : buffer address of the beat (source)
//   rd_last  : final beat of the drain (source)
// Handshake: a beat transfers on a rising edge where rd_valid && rd_ready.
// Once rd_valid is high, rd_data/rd_addr/rd_last are held stable until that
// transfer; rd_ready while rd_valid is low has no effect.
interface output_buffer_drain_if
  import output_buffer_drain_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) ();

  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_last;

  modport master (
    output rd_valid,
    output rd_data,
    output rd_addr,
    output rd_last,
    input  rd_ready
  );

  modport slave (
    input  rd_valid,
    input  rd_data,
    input  rd_addr,
    input  rd_last,
    output rd_ready
  );

endinterface

// File: rtl/output_buffer_drain_regfile.sv
// outbuf_regfile: 1-write / 1-read register file with per-entry written flags.
// Ports:
//   clk, rst     : clock, async active-high reset (clears entry_valid only)
//   wr_en/addr/data : write port from the accumulator, never stalled
//   raddr, rdata : combinational read; a same-cycle write to raddr is
//                  forwarded so the reader sees the new data
//   clr_en/addr  : scrub one entry (zero data, clear flag); a coincident
//                  write to the same entry takes priority
//   entry_valid  : per-entry written flag
module outbuf_regfile
  import output_buffer_drain_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  output logic [DEPTH-1:0]  entry_valid
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Contents survive reset; only the written flags are cleared.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_en && wr_addr == ADDR_W'(i)) begin
        mem[i] <= wr_data;
      end else if (clr_en && clr_addr == ADDR_W'(i)) begin
        mem[i] <= DATA_W'(BFP32_ZERO);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry_valid <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_en && wr_addr == ADDR_W'(i)) begin
          entry_valid[i] <= 1'b1;
        end else if (clr_en && clr_addr == ADDR_W'(i)) begin
          entry_valid[i] <= 1'b0;
        end
      end
    end
  end

  assign rdata = (wr_en && wr_addr == raddr) ? wr_data : mem[raddr];

endmodule

// File: rtl/output_buffer_drain.sv
// output_buffer_drain: captures accumulator writes into a DEPTH x DATA_W
// buffer and streams a requested window of entries to the host/DMA side.
// Ports:
//   clk, rst                 : clock, async active-high reset
//   output_buffer_enable/addr, output_data : accumulator write port
//   drain_start/addr/len     : drain request (len 0..DEPTH, larger clamps)
//   rd                       : read-back stream (output_buffer_drain_if.master)
//   busy                     : drain in progress
//   done                     : one-cycle pulse at drain completion
//   entry_valid              : per-entry written flag
//   state_dbg                : drain FSM state
// Build option: define OUTBUF_CLEAR_ON_READ_EN to make drains destructive
// (each accepted beat zeroes its entry and clears its written flag).
// Each beat costs two cycles: LOAD registers the entry, SEND holds it until
// the consumer accepts. DEPTH must equal 2**ADDR_W so the pointer wraps
// naturally.
module output_buffer_drain
  import output_buffer_drain_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 output_buffer_enable,
  input  logic [ADDR_W-1:0]    output_buffer_addr,
  input  logic [DATA_W-1:0]    output_data,
  input  logic                 drain_start,
  input  logic [ADDR_W-1:0]    drain_addr,
  input  logic [ADDR_W:0]      drain_len,
  output_buffer_drain_if.master rd,
  output logic                 busy,
  output logic                 done,
  output logic [DEPTH-1:0]     entry_valid,
  output drain_state_e         state_dbg
);

  localparam logic [ADDR_W:0] DEPTH_LEN = (ADDR_W+1)'(DEPTH);

  drain_state_e      state, state_d;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0]   remaining;
  logic [ADDR_W:0]   len_clamped;
  logic              rd_valid_q;
  logic [DATA_W-1:0] rd_data_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              rd_last_q;
  logic              start_ok;
  logic              hs;
  logic              clr_en;
  logic [DATA_W-1:0] rf_rdata;

  assign len_clamped = (drain_len > DEPTH_LEN) ? DEPTH_LEN : drain_len;

  always_comb begin
    state_d  = state;
    start_ok = 1'b0;
    hs       = 1'b0;
    case (state)
      IDLE: begin
        if (drain_start) begin
          start_ok = 1'b1;
          state_d  = (len_clamped == '0) ? FIN : LOAD;
        end
      end
      LOAD: state_d = SEND;
      SEND: begin
        // rd_valid is always high here, so rd_ready alone completes the beat.
        if (rd.rd_ready) begin
          hs      = 1'b1;
          state_d = rd_last_q ? FIN : LOAD;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      remaining  <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_addr_q  <= '0;
      rd_last_q  <= 1'b0;
    end else begin
      state <= state_d;
      if (start_ok) begin
        ptr       <= drain_addr;
        remaining <= len_clamped;
      end
      if (state == LOAD) begin
        rd_data_q  <= rf_rdata;
        rd_addr_q  <= ptr;
        rd_last_q  <= (remaining == (ADDR_W+1)'(1));
        rd_valid_q <= 1'b1;
      end
      if (hs) begin
        ptr        <= ptr + 1'b1;
        remaining  <= remaining - 1'b1;
        rd_valid_q <= 1'b0;
      end
    end
  end

`ifdef OUTBUF_CLEAR_ON_READ_EN
  assign clr_en = hs;
`else
  assign clr_en = 1'b0;
`endif

  outbuf_regfile #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) u_regfile (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (output_buffer_enable),
    .wr_addr    (output_buffer_addr),
    .wr_data    (output_data),
    .raddr      (ptr),
    .rdata      (rf_rdata),
    .clr_en     (clr_en),
    .clr_addr   (rd_addr_q),
    .entry_valid(entry_valid)
  );

  assign rd.rd_valid = rd_valid_q;
  assign rd.rd_data  = rd_data_q;
  assign rd.rd_addr  = rd_addr_q;
  assign rd.rd_last  = rd_last_q;
  assign busy        = (state != IDLE);
  assign done        = (state == FIN);
  assign state_dbg   = state;

endmodule
